// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle signed/unsigned multiply and divide with HI/LO registers.
// Magnitudes are iterated in a shared 64-bit register; sign fixup happens in DONE.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       MDControl,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                           OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    logic [1:0]         state;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] p, mul_next, div_next, prod_f;
    logic [WIDTH-1:0]   m, a_raw, in_a_mag, in_b_mag, res_hi, res_lo;
    logic [WIDTH:0]     msum, r, diff;
    logic               is_div, neg_q, neg_r, sgn_in, arith_in, div_in;

    assign busy     = state != IDLE;
    assign sgn_in   = MDControl == OP_MULT || MDControl == OP_DIV;
    assign div_in   = MDControl == OP_DIV || MDControl == OP_DIVU;
    assign arith_in = MDControl == OP_MULT || MDControl == OP_MULTU || div_in;
    assign in_a_mag = sgn_in && OperandA[WIDTH-1] ? -OperandA : OperandA;
    assign in_b_mag = sgn_in && OperandB[WIDTH-1] ? -OperandB : OperandB;

    // Multiply: low half holds the shrinking multiplier, high half accumulates.
    assign msum     = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    assign mul_next = {msum, p[WIDTH-1:1]};
    // Divide: partial remainder in the high half, quotient bits shift in at the bottom.
    assign r        = p[2*WIDTH-1:WIDTH-1];
    assign diff     = r - {1'b0, m};
    assign div_next = diff[WIDTH] ? {r[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

    always_comb begin
        prod_f = neg_q ? -p : p;
        res_hi = prod_f[2*WIDTH-1:WIDTH];
        res_lo = prod_f[WIDTH-1:0];
        if (is_div) begin
            res_hi = m == '0 ? a_raw : neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
            res_lo = m == '0 ? '1 : neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (arith_in) begin
                        a_raw  <= OperandA;
                        m      <= div_in ? in_b_mag : in_a_mag;
                        p      <= {{WIDTH{1'b0}}, div_in ? in_a_mag : in_b_mag};
                        is_div <= div_in;
                        neg_q  <= sgn_in && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                        neg_r  <= sgn_in && OperandA[WIDTH-1];
                        cnt    <= '0;
                        state  <= div_in ? DIV : MUL;
                    end else if (MDControl == OP_MTHI) HI <= OperandA;
                    else if (MDControl == OP_MTLO) LO <= OperandA;
                end
                MUL, DIV: begin
                    p     <= state == DIV ? div_next : mul_next;
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'(WIDTH - 1) ? DONE : state;
                end
                default: begin
                    HI    <= res_hi;
                    LO    <= res_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo, saved;
    logic        busy, done;
    int          tests = 0, fails = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .MDControl(op), .OperandA(a), .OperandB(b),
        .HI(hi), .LO(lo), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, rm;
        logic [63:0] ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o == 3'd1) return sx * sy;
        if (o == 3'd2) return ux * uy;
        if (y == 32'b0) return {x, 32'hFFFFFFFF};
        if (o == 3'd3) begin
            q  = sx / sy;
            rm = sx % sy;
            return {rm[31:0], q[31:0]};
        end
        q  = longint'(ux / uy);
        rm = longint'(ux % uy);
        return {rm[31:0], q[31:0]};
    endfunction

    always @(negedge clk) if (done === 1'b1) begin
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got HI=%h LO=%h expected no done pulse", hi, lo);
        end else chk("result", {hi, lo}, sb.pop_front());
    end

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int cyc;
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            chk("busy_during", {63'b0, busy}, 64'd1);
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 34);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi", {hi, lo}, {32'h12345678, 32'h0});
        chk("mthi_busy_done", {62'b0, busy, done}, 64'd0);
        start = 1'b1; op = 3'd6; a = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; op = i == 0 ? 3'd0 : 3'd7; a = $urandom; b = $urandom;
            @(negedge clk);
            start = 1'b0;
            chk("nop_hilo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});
            chk("nop_busy", {63'b0, busy}, 64'd0);
        end
        run(3'd1, 32'hFFFFFFFF, 32'h2);
        chk("mult_neg1x2", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFE});
        run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
        run(3'd3, 32'hFFFFFFF9, 32'h2);
        chk("div_m7_2", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run(3'd4, 32'd100, 32'd7);
        chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        run(3'd4, 32'h64, 32'h0);
        chk("divu_by0", {hi, lo}, {32'h64, 32'hFFFFFFFF});
        run(3'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf", {hi, lo}, {32'h0, 32'h80000000});
        // MTLO during a multiply must be dropped.
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
        sb.push_back(model(3'd1, 32'd3, 32'd5));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        saved = lo;
        start = 1'b1; op = 3'd6; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_busy_lo", {32'b0, lo}, {32'b0, saved});
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("mtlo_busy_result", {hi, lo}, {32'h0, 32'd15});
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(1) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
            run(3'($urandom_range(4, 1)), pick(), pick());
        end
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = $urandom; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_mid", {63'b0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        repeat (40) begin
            @(negedge clk);
            chk("abort_no_done", {63'b0, done}, 64'd0);
        end
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
